// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for an RV32I-style datapath: fetch, decode,
// execute, memory and write-back phases, with a sticky trap for unsupported opcodes.
module cpu_sequencer #(
    parameter int OPWIDTH  = 7,
    parameter int REGWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPWIDTH-1:0]  opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                branch_taken,
    output logic                imem_req,
    output logic                ir_write,
    output logic                dmem_rd,
    output logic                dmem_wr,
    output logic                reg_write,
    output logic                pc_write,
    output logic [1:0]          pc_sel,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [REGWIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [OPWIDTH-1:0] OP_RTYPE  = OPWIDTH'(7'b0110011);
    localparam logic [OPWIDTH-1:0] OP_IARITH = OPWIDTH'(7'b0010011);
    localparam logic [OPWIDTH-1:0] OP_ILOAD  = OPWIDTH'(7'b0000011);
    localparam logic [OPWIDTH-1:0] OP_STYPE  = OPWIDTH'(7'b0100011);
    localparam logic [OPWIDTH-1:0] OP_BTYPE  = OPWIDTH'(7'b1100011);
    localparam logic [OPWIDTH-1:0] OP_JAL    = OPWIDTH'(7'b1101111);
    localparam logic [OPWIDTH-1:0] OP_JALR   = OPWIDTH'(7'b1100111);
    localparam logic [OPWIDTH-1:0] OP_LUI    = OPWIDTH'(7'b0110111);
    localparam logic [OPWIDTH-1:0] OP_AUIPC  = OPWIDTH'(7'b0010111);

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_IMM  = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;

    state_t                state_reg;
    state_t                state_next;
    logic [OPWIDTH-1:0]    op_reg;
    logic [REGWIDTH-1:0]   retired_reg;

    logic                  opcode_legal;
    logic                  imem_req_next;
    logic                  ir_write_next;
    logic                  dmem_rd_next;
    logic                  dmem_wr_next;
    logic                  reg_write_next;
    logic                  pc_write_next;
    logic [1:0]            pc_sel_next;
    logic                  illegal_next;

    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_IARITH, OP_ILOAD, OP_STYPE, OP_BTYPE,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default:                           opcode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // The opcode is only sampled in DECODE; later phases work from op_reg alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg <= '0;
        end else if (state_reg == S_DECODE) begin
            op_reg <= opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (pc_write_next) begin
            retired_reg <= retired_reg + REGWIDTH'(1);
        end
    end

    always_comb begin
        state_next     = state_reg;
        imem_req_next  = 1'b0;
        ir_write_next  = 1'b0;
        dmem_rd_next   = 1'b0;
        dmem_wr_next   = 1'b0;
        reg_write_next = 1'b0;
        pc_write_next  = 1'b0;
        pc_sel_next    = SEL_PC4;
        illegal_next   = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_req_next = 1'b1;
                if (imem_ready) begin
                    ir_write_next = 1'b1;
                    state_next    = S_DECODE;
                end
            end

            S_DECODE: begin
                state_next = opcode_legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (op_reg == OP_ILOAD || op_reg == OP_STYPE) begin
                    state_next = S_MEM;
                end else if (op_reg == OP_BTYPE) begin
                    pc_write_next = 1'b1;
                    pc_sel_next   = branch_taken ? SEL_IMM : SEL_PC4;
                    state_next    = S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end

            S_MEM: begin
                if (op_reg == OP_ILOAD) begin
                    dmem_rd_next = 1'b1;
                    if (dmem_ready) begin
                        state_next = S_WB;
                    end
                end else if (op_reg == OP_STYPE) begin
                    dmem_wr_next = 1'b1;
                    if (dmem_ready) begin
                        pc_write_next = 1'b1;
                        state_next    = S_FETCH;
                    end
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_WB: begin
                reg_write_next = 1'b1;
                pc_write_next  = 1'b1;
                if (op_reg == OP_JAL) begin
                    pc_sel_next = SEL_IMM;
                end else if (op_reg == OP_JALR) begin
                    pc_sel_next = SEL_JALR;
                end
                state_next = S_FETCH;
            end

            S_TRAP: begin
                illegal_next = 1'b1;
                state_next   = S_TRAP;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Gate with rst so strobes drop in the same cycle reset arrives, even mid-access.
    assign imem_req  = imem_req_next  & ~rst;
    assign ir_write  = ir_write_next  & ~rst;
    assign dmem_rd   = dmem_rd_next   & ~rst;
    assign dmem_wr   = dmem_wr_next   & ~rst;
    assign reg_write = reg_write_next & ~rst;
    assign pc_write  = pc_write_next  & ~rst;
    assign pc_sel    = rst ? SEL_PC4 : pc_sel_next;
    assign illegal   = illegal_next   & ~rst;
    assign state     = state_reg;
    assign retired   = retired_reg;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have parameter OPWIDTH, default 7, meaning the opcode field width.
REQ-002 The block SHALL have parameter REGWIDTH, default 32, meaning the retired-instruction counter width.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 opcode  input  OPWIDTH  instruction[6:0] from the instruction register; valid from the DECODE cycle onward.
REQ-006 imem_ready  input  1  instruction memory has returned data this cycle.
REQ-007 dmem_ready  input  1  data memory has completed the access this cycle.
REQ-008 branch_taken  input  1  ALU branch comparison result; valid in EXEC.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 ir_write  output  1  load the instruction register.
REQ-011 dmem_rd / dmem_wr  output  1 each  data memory read / write strobe.
REQ-012 reg_write  output  1  register-file write enable (Decoder Write input).
REQ-013 pc_write  output  1  update the PC.
REQ-014 pc_sel  output  2  00 = pc+4, 01 = pc+imm (branch/JAL), 10 = (rs1+imm)&~1 (JALR).
REQ-015 state  output  3  current FSM state, for debug.
REQ-016 illegal  output  1  unsupported opcode trapped.
REQ-017 retired  output  REGWIDTH  count of completed instructions.

Function
REQ-018 The FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6–7 SHALL go to FETCH on the next edge.
REQ-019 Legal opcodes SHALL be RTYPE 0110011, IARITH 0010011, ILOAD 0000011, STYPE 0100011, BTYPE 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-020 FETCH: imem_req=1; ir_write=1 combinationally in the cycle imem_ready=1, then go to DECODE; otherwise stay in FETCH.
REQ-021 DECODE: latch opcode into an internal op register; go to TRAP if the opcode is illegal, else go to EXEC.
REQ-022 EXEC: ILOAD or STYPE → MEM; BTYPE → FETCH with pc_write=1, pc_sel=01 if branch_taken else 00; all other opcodes → WB.
REQ-023 MEM: hold dmem_rd=1 (ILOAD) or dmem_wr=1 (STYPE) continuously until dmem_ready=1. On completion, ILOAD → WB; STYPE → FETCH with pc_write=1, pc_sel=00.
REQ-024 WB: reg_write=1 and pc_write=1 for exactly one cycle, then → FETCH. pc_sel=01 for JAL, 10 for JALR, 00 otherwise.
REQ-025 TRAP: illegal=1; all strobes 0; the FSM SHALL remain in TRAP until rst.
REQ-026 All strobes SHALL be 0 in every state/condition not listed above; dmem_rd and dmem_wr SHALL never both be 1.
REQ-027 retired SHALL increment by 1 on every cycle with pc_write=1 and SHALL wrap modulo 2^REGWIDTH.
REQ-028 Minimum cycles per instruction (memories ready immediately): BTYPE 3, STYPE 4, ILOAD 5, all others 4.
REQ-029 Opcode changes after DECODE SHALL NOT affect sequencing; only op_q is used from EXEC onward.
REQ-030 A ready input asserted outside its waiting state SHALL be ignored.

Reset
REQ-031 While rst=1: state=FETCH, op_q=0, retired=0, illegal=0, and all strobes 0. Strobes SHALL clear immediately, not at the next edge, including mid-access in MEM.
REQ-032 imem_req SHALL assert in the first cycle after rst deasserts.

Verification
REQ-033 ADDI (0010011), both readys tied 1 → states 0,1,2,4,0; reg_write and pc_write high only in WB; retired 0→1.
REQ-034 LW (0000011), dmem_ready low for 3 cycles in MEM → dmem_rd high 4 cycles; then WB with reg_write=1; CPI 8.
REQ-035 BEQ (1100011) with branch_taken=1, then again with 0 → pc_sel=01 then 00 in EXEC; reg_write never asserts; retired +2.
REQ-036 JALR (1100111) → WB with pc_sel=10 and reg_write=1; JAL → pc_sel=01.
REQ-037 Opcode 1111111 → TRAP after DECODE; illegal=1; no strobes for 20 cycles; rst → FETCH, illegal=0.
REQ-038 SW (0100011), rst pulsed mid-MEM → dmem_wr drops in the same cycle; retired=0; the FSM restarts in FETCH.
